// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: datapath widths and ALU opcode encodings.
package alu_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int CNT_W    = 16;

    localparam logic [3:0] OP_ADD = 4'hF;
    localparam logic [3:0] OP_SUB = 4'hE;
    localparam logic [3:0] OP_INC = 4'hD;
    localparam logic [3:0] OP_DEC = 4'hC;
    localparam logic [3:0] OP_AND = 4'h7;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h4;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU issue stage: two operand read ports and one debug read port,
// all combinational, plus one synchronous write port. R0 always reads as zero and ignores writes.
module alu_regfile import alu_pkg::*; #(
    parameter int WIDTH = DATA_W,
    parameter int AW    = REG_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic [AW-1:0]    dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] regs [DEPTH];

    // Synchronous clear of every entry on reset; writes to R0 are dropped so it stays zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Combinational reads with R0 forced to zero regardless of storage contents.
    always_comb begin
        rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
        rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
        dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
    end

endmodule

// File: rtl/alu_operand_fetch.sv
// Issue stage in front of the 32-bit ALU. Cycle N accepts an instruction and reads its
// operands (forwarding the in-flight ALU result when needed); cycle N+1 presents the operands
// to the ALU from the execute register and writes the result and flags back at its closing edge.
module alu_operand_fetch #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int REG_AW = alu_pkg::REG_AW,
    parameter int CNT_W  = alu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              instr_use_imm,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              hold,
    output logic              alu_status,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              flag_cout,
    output logic              flag_ovf,
    output logic              flag_zero,
    output logic [CNT_W-1:0]  retired_cnt,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic              ex_valid;
    logic [REG_AW-1:0] ex_rd;
    logic              accept;
    logic              writeback;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign instr_ready = !hold;
    assign accept      = instr_valid && instr_ready;
    assign writeback   = ex_valid && !hold;
    assign alu_status  = ex_valid;

    alu_regfile #(
        .WIDTH (DATA_W),
        .AW    (REG_AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (writeback),
        .waddr     (ex_rd),
        .wdata     (alu_result),
        .raddr_a   (instr_rs1),
        .rdata_a   (rf_a),
        .raddr_b   (instr_rs2),
        .rdata_b   (rf_b),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    // Operand selection: R0 is zero, the in-flight result bypasses the register file, else read it.
    always_comb begin
        opnd_a = rf_a;
        opnd_b = rf_b;
        if (instr_rs1 == '0) begin
            opnd_a = '0;
        end else if (ex_valid && (ex_rd == instr_rs1)) begin
            opnd_a = alu_result;
        end
        if (instr_use_imm) begin
            opnd_b = instr_imm;
        end else if (instr_rs2 == '0) begin
            opnd_b = '0;
        end else if (ex_valid && (ex_rd == instr_rs2)) begin
            opnd_b = alu_result;
        end
    end

    // Execute register: loads on accept, drains when idle, and freezes entirely under hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_rd      <= instr_rd;
            alu_a      <= opnd_a;
            alu_b      <= opnd_b;
            alu_opcode <= instr_op;
        end else if (!hold) begin
            ex_valid   <= 1'b0;
        end
    end

    // Retire bookkeeping: flags from the writing-back instruction and a wrapping retire count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_cout   <= 1'b0;
            flag_ovf    <= 1'b0;
            flag_zero   <= 1'b0;
            retired_cnt <= '0;
        end else if (writeback) begin
            flag_cout   <= alu_cout;
            flag_ovf    <= alu_overflow;
            flag_zero   <= (alu_result == '0);
            retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Self-checking bench for alu_operand_fetch. The bench plays the ALU, keeps its own
// architectural register model, and scoreboards each issued instruction's expected result.
module tb_alu_operand_fetch;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_op;
    logic [AW-1:0] instr_rd;
    logic [AW-1:0] instr_rs1;
    logic [AW-1:0] instr_rs2;
    logic          instr_use_imm;
    logic [DW-1:0] instr_imm;
    logic          hold;
    logic          alu_status;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_opcode;
    logic [DW-1:0] alu_result;
    logic          alu_cout;
    logic          alu_overflow;
    logic          flag_cout;
    logic          flag_ovf;
    logic          flag_zero;
    logic [CW-1:0] retired_cnt;
    logic [AW-1:0] dbg_raddr;
    logic [DW-1:0] dbg_rdata;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] res;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] arch [8];
    logic [CW-1:0] exp_cnt;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    alu_operand_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_op      (instr_op),
        .instr_rd      (instr_rd),
        .instr_rs1     (instr_rs1),
        .instr_rs2     (instr_rs2),
        .instr_use_imm (instr_use_imm),
        .instr_imm     (instr_imm),
        .hold          (hold),
        .alu_status    (alu_status),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .alu_overflow  (alu_overflow),
        .flag_cout     (flag_cout),
        .flag_ovf      (flag_ovf),
        .flag_zero     (flag_zero),
        .retired_cnt   (retired_cnt),
        .dbg_raddr     (dbg_raddr),
        .dbg_rdata     (dbg_rdata)
    );

    // Reference ALU: returns {cout, overflow, result}; unknown opcodes give 0.
    function automatic logic [DW+1:0] alu_model(input logic [3:0] op, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        logic          c;
        logic          v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[DW-1:0];
                c = s[DW];
                v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[DW-1:0];
                c = s[DW];
                v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            OP_INC: begin
                s = {1'b0, a} + 33'd1;
                r = s[DW-1:0];
                c = s[DW];
                v = !a[DW-1] && r[DW-1];
            end
            OP_DEC: begin
                s = {1'b0, a} + {1'b0, {DW{1'b1}}};
                r = s[DW-1:0];
                c = s[DW];
                v = a[DW-1] && !r[DW-1];
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    // The bench acts as the combinational ALU fed by the execute register.
    assign {alu_cout, alu_overflow, alu_result} = alu_model(alu_opcode, alu_a, alu_b);

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one instruction (caller guarantees hold=0) and records its expected retirement.
    task automatic apply_stimulus(input logic [3:0] op, input logic [AW-1:0] rd,
                                  input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                  input logic use_imm, input logic [DW-1:0] imm);
        logic [DW+1:0] r;
        exp_t          e;
        r = alu_model(op, arch[rs1], use_imm ? imm : arch[rs2]);
        e.rd   = rd;
        e.res  = r[DW-1:0];
        e.ovf  = r[DW];
        e.cout = r[DW+1];
        sb.push_back(e);
        if (rd != '0) arch[rd] = e.res;
        instr_op      = op;
        instr_rd      = rd;
        instr_rs1     = rs1;
        instr_rs2     = rs2;
        instr_use_imm = use_imm;
        instr_imm     = imm;
        instr_valid   = 1'b1;
        @(posedge clk);
        #1;
        instr_valid   = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_raddr = i[AW-1:0];
            #1;
            check_output($sformatf("%s_r%0d", tag, i), dbg_rdata, arch[i]);
        end
    endtask

    // Retirement monitor: whenever a writeback is due at the next edge, compare against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && alu_status === 1'b1 && hold === 1'b0) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_wb", alu_status, 0);
                end else begin
                    e = sb.pop_front();
                    check_output("alu_result", alu_result, e.res);
                    @(posedge clk);
                    #1;
                    exp_cnt++;
                    check_output("flag_cout", flag_cout, e.cout);
                    check_output("flag_ovf", flag_ovf, e.ovf);
                    check_output("flag_zero", flag_zero, e.res == '0);
                    check_output("retired_cnt", retired_cnt, exp_cnt);
                end
            end
        end
    end

    initial begin
        logic [3:0]    ops [10];
        logic [DW-1:0] a_exp;
        logic [DW-1:0] r7_before;
        logic [CW-1:0] cnt_before;

        ops = '{OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_XOR, OP_NOT, 4'h0, 4'h9};
        for (int i = 0; i < 8; i++) arch[i] = '0;
        exp_cnt       = '0;
        rst_n         = 1'b0;
        hold          = 1'b0;
        instr_valid   = 1'b0;
        instr_op      = '0;
        instr_rd      = '0;
        instr_rs1     = '0;
        instr_rs2     = '0;
        instr_use_imm = 1'b0;
        instr_imm     = '0;
        dbg_raddr     = '0;

        // Reset state
        idle(2);
        check_output("rst_ready", instr_ready, 1);
        check_output("rst_status", alu_status, 0);
        check_output("rst_alu_a", alu_a, 0);
        check_output("rst_alu_b", alu_b, 0);
        check_output("rst_opcode", alu_opcode, 0);
        check_output("rst_flags", {flag_cout, flag_ovf, flag_zero}, 0);
        check_output("rst_cnt", retired_cnt, 0);
        check_regs("rst");
        rst_n = 1'b1;

        // Immediate loads, then a back-to-back dependent add through the forwarding path
        apply_stimulus(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        apply_stimulus(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 32'd7);
        apply_stimulus(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 32'd0);
        idle(2);
        check_output("r3_forwarded", arch[3], 32'd12);
        check_regs("load");
        check_output("cnt_load", retired_cnt, 3);

        // Zero result and register-form logic op
        apply_stimulus(OP_SUB, 3'd6, 3'd3, 3'd0, 1'b1, 32'd12);
        apply_stimulus(OP_XOR, 3'd6, 3'd1, 3'd2, 1'b0, 32'd0);
        idle(2);
        check_regs("logic");

        // Hold with an instruction in execute; a second offer during hold must be ignored
        r7_before  = arch[7];
        a_exp      = arch[3];
        cnt_before = exp_cnt;
        apply_stimulus(OP_ADD, 3'd7, 3'd3, 3'd0, 1'b1, 32'd100);
        hold          = 1'b1;
        instr_valid   = 1'b1;
        instr_rd      = 3'd2;
        instr_rs1     = 3'd1;
        instr_use_imm = 1'b1;
        instr_imm     = 32'hDEAD;
        dbg_raddr     = 3'd7;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_output("hold_ready", instr_ready, 0);
            check_output("hold_status", alu_status, 1);
            check_output("hold_alu_a", alu_a, a_exp);
            check_output("hold_alu_b", alu_b, 32'd100);
            check_output("hold_cnt", retired_cnt, cnt_before);
            check_output("hold_r7", dbg_rdata, r7_before);
        end
        hold        = 1'b0;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("release_cnt", retired_cnt, cnt_before + 1'b1);
        check_output("release_r7", dbg_rdata, arch[7]);
        @(posedge clk);
        #1;
        check_output("release_once", retired_cnt, cnt_before + 1'b1);
        check_output("release_status", alu_status, 0);

        // Signed overflow, with the result aimed at R0
        apply_stimulus(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF);
        apply_stimulus(OP_ADD, 3'd0, 3'd4, 3'd0, 1'b1, 32'd1);
        idle(1);
        check_output("ovf_flag", flag_ovf, 1);
        idle(1);
        check_regs("ovf");

        // Back-to-back random mix including unsupported opcodes
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(ops[$urandom_range(0, 9)], AW'($urandom_range(0, 7)),
                           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), $urandom());
        end
        idle(2);
        check_regs("rand");

        // Reset during the execute cycle discards the in-flight instruction
        apply_stimulus(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'd9);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
        for (int i = 0; i < 8; i++) arch[i] = '0;
        check_output("midrst_cnt", retired_cnt, exp_cnt);
        check_output("midrst_status", alu_status, 0);
        idle(1);
        check_regs("midrst");
        check_output("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
